// File: rtl/store_buffer_pkg.sv
// store_buffer_pkg: shared widths, size encodings and entry layout for the store buffer.
// No ports. Provides XLEN, ROB_INDEX_WIDTH, SB_INDEX_WIDTH, DEPTH, the
// SB_SIZE_* encodings (shared with the load buffer and memory interface),
// the pointer/count types and the entry record.
package store_buffer_pkg;
    localparam int XLEN            = 32;
    localparam int ROB_INDEX_WIDTH = 8;
    localparam int SB_INDEX_WIDTH  = 3;
    localparam int DEPTH           = 1 << SB_INDEX_WIDTH;

    localparam logic [1:0] SB_SIZE_BYTE = 2'd0;
    localparam logic [1:0] SB_SIZE_HALF = 2'd1;
    localparam logic [1:0] SB_SIZE_WORD = 2'd2;

    typedef logic [SB_INDEX_WIDTH-1:0] sb_ptr_t;
    typedef logic [SB_INDEX_WIDTH:0]   sb_cnt_t;

    typedef struct packed {
        logic                       valid;
        logic [ROB_INDEX_WIDTH-1:0] rob_index;
        logic [1:0]                 size;
        logic                       addr_valid;
        logic [XLEN-1:0]            address;
        logic [XLEN-1:0]            value;
        logic                       committed;
    } sb_entry_t;
endpackage

// File: rtl/store_buffer_if.sv
// store_buffer_if: bundles the store buffer's issue, AGU, commit, memory and broadcast channels.
// Ports: none. Modport slave is the store buffer itself; modport master is
// the surrounding core (dispatch, AGU, ROB, data memory, load buffer).
interface store_buffer_if;
    import store_buffer_pkg::*;

    logic                       flush;
    logic                       issue_ready;
    logic                       issue_valid;
    logic [ROB_INDEX_WIDTH-1:0] issue_ROB_index;
    logic [1:0]                 issue_size;
    logic                       data_receive_ready;
    logic                       data_receive_valid;
    logic [ROB_INDEX_WIDTH-1:0] data_receive_ROB_index;
    logic [XLEN-1:0]            data_receive_address;
    logic [XLEN-1:0]            data_receive_value;
    logic                       commit_ready;
    logic                       commit_valid;
    logic [ROB_INDEX_WIDTH-1:0] commit_ROB_index;
    logic                       store_request_valid;
    logic                       store_request_ready;
    logic [XLEN-1:0]            store_request_address;
    logic [XLEN-1:0]            store_request_value;
    logic [1:0]                 store_request_size;
    logic                       store_commit_valid;
    logic [XLEN-1:0]            store_commit_address;

    modport slave (
        input  flush, issue_valid, issue_ROB_index, issue_size,
        input  data_receive_valid, data_receive_ROB_index, data_receive_address, data_receive_value,
        input  commit_valid, commit_ROB_index, store_request_ready,
        output issue_ready, data_receive_ready, commit_ready,
        output store_request_valid, store_request_address, store_request_value, store_request_size,
        output store_commit_valid, store_commit_address
    );

    modport master (
        output flush, issue_valid, issue_ROB_index, issue_size,
        output data_receive_valid, data_receive_ROB_index, data_receive_address, data_receive_value,
        output commit_valid, commit_ROB_index, store_request_ready,
        input  issue_ready, data_receive_ready, commit_ready,
        input  store_request_valid, store_request_address, store_request_value, store_request_size,
        input  store_commit_valid, store_commit_address
    );
endinterface

// File: rtl/store_buffer_sb_tag_match.sv
// sb_tag_match: combinational one-hot match of a ROB tag against the valid entries.
// Ports: valid_i (entry valid bits), tags_i (entry ROB tags), req_i (lookup
// strobe), tag_i (tag to find), match_o (one-hot hit vector, zero on miss).
module sb_tag_match
    import store_buffer_pkg::*;
(
    input  logic [DEPTH-1:0]                      valid_i,
    input  logic [DEPTH-1:0][ROB_INDEX_WIDTH-1:0] tags_i,
    input  logic                                  req_i,
    input  logic [ROB_INDEX_WIDTH-1:0]            tag_i,
    output logic [DEPTH-1:0]                      match_o
);
    always_comb begin
        match_o = '0;
        for (int i = 0; i < DEPTH; i++)
            match_o[i] = req_i && valid_i[i] && (tags_i[i] == tag_i);
    end
endmodule

// File: rtl/store_buffer.sv
// store_buffer: in-order circular buffer of in-flight stores draining to data memory.
// Ports: clock_i (clock), reset_i (synchronous, active-low reset),
// sb_if (slave modport: issue, AGU data, ROB commit, memory request and
// load-buffer commit broadcast).
module store_buffer
    import store_buffer_pkg::*;
(
    input logic           clock_i,
    input logic           reset_i,
    store_buffer_if.slave sb_if
);
    sb_entry_t                             ent_q [DEPTH];
    sb_entry_t                             ent_d [DEPTH];
    sb_ptr_t                               head_q, head_d, tail_q, tail_d;
    sb_cnt_t                               count_q, count_d, n_comm;
    logic                                  sc_valid_q;
    logic [XLEN-1:0]                       sc_addr_q;
    logic [DEPTH-1:0]                      valid_vec, comm_vec, data_hit, commit_hit;
    logic [DEPTH-1:0][ROB_INDEX_WIDTH-1:0] tag_vec;
    logic                                  issue_fire, drain_fire;

    // Committed entries are contiguous from head, so their count locates the
    // post-flush tail.
    always_comb begin
        valid_vec = '0;
        comm_vec  = '0;
        tag_vec   = '0;
        n_comm    = '0;
        for (int i = 0; i < DEPTH; i++) begin
            valid_vec[i] = ent_q[i].valid;
            tag_vec[i]   = ent_q[i].rob_index;
            comm_vec[i]  = ent_q[i].valid && ent_q[i].committed;
            n_comm       = n_comm + sb_cnt_t'(comm_vec[i]);
        end
    end

    sb_tag_match u_data_match (
        .valid_i (valid_vec),
        .tags_i  (tag_vec),
        .req_i   (sb_if.data_receive_valid),
        .tag_i   (sb_if.data_receive_ROB_index),
        .match_o (data_hit)
    );

    sb_tag_match u_commit_match (
        .valid_i (valid_vec),
        .tags_i  (tag_vec),
        .req_i   (sb_if.commit_valid),
        .tag_i   (sb_if.commit_ROB_index),
        .match_o (commit_hit)
    );

    assign sb_if.issue_ready           = reset_i && (count_q < sb_cnt_t'(DEPTH));
    assign sb_if.data_receive_ready    = reset_i;
    assign sb_if.commit_ready          = reset_i;
    assign sb_if.store_request_valid   = reset_i && ent_q[head_q].valid && ent_q[head_q].committed
                                         && ent_q[head_q].addr_valid;
    assign sb_if.store_request_address = ent_q[head_q].address;
    assign sb_if.store_request_value   = ent_q[head_q].value;
    assign sb_if.store_request_size    = ent_q[head_q].size;
    assign sb_if.store_commit_valid    = reset_i && sc_valid_q;
    assign sb_if.store_commit_address  = sc_addr_q;

    assign issue_fire = sb_if.issue_valid && sb_if.issue_ready;
    assign drain_fire = sb_if.store_request_valid && sb_if.store_request_ready;

    // Issue can never target the head being drained: that needs count==DEPTH,
    // where issue is blocked. Drain is applied last so it always wins on head.
    always_comb begin
        ent_d  = ent_q;
        head_d = head_q;
        tail_d = tail_q;
        if (sb_if.flush) begin
            for (int i = 0; i < DEPTH; i++)
                if (!ent_q[i].committed) begin
                    ent_d[i].valid      = 1'b0;
                    ent_d[i].addr_valid = 1'b0;
                end
            tail_d = head_q + n_comm[SB_INDEX_WIDTH-1:0];
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (data_hit[i]) begin
                    ent_d[i].address    = sb_if.data_receive_address;
                    ent_d[i].value      = sb_if.data_receive_value;
                    ent_d[i].addr_valid = 1'b1;
                end
                if (commit_hit[i])
                    ent_d[i].committed = 1'b1;
            end
            if (issue_fire) begin
                ent_d[tail_q] = '{valid: 1'b1, rob_index: sb_if.issue_ROB_index, size: sb_if.issue_size,
                                  addr_valid: 1'b0, address: '0, value: '0, committed: 1'b0};
                tail_d = tail_q + 1'b1;
            end
        end
        if (drain_fire) begin
            ent_d[head_q].valid     = 1'b0;
            ent_d[head_q].committed = 1'b0;
            head_d = head_q + 1'b1;
        end
        count_d = sb_if.flush ? n_comm - sb_cnt_t'(drain_fire)
                              : count_q + sb_cnt_t'(issue_fire) - sb_cnt_t'(drain_fire);
    end

    always_ff @(posedge clock_i) begin
        if (!reset_i) begin
            for (int i = 0; i < DEPTH; i++)
                ent_q[i] <= '0;
            head_q     <= '0;
            tail_q     <= '0;
            count_q    <= '0;
            sc_valid_q <= 1'b0;
            sc_addr_q  <= '0;
        end else begin
            ent_q      <= ent_d;
            head_q     <= head_d;
            tail_q     <= tail_d;
            count_q    <= count_d;
            sc_valid_q <= drain_fire;
            sc_addr_q  <= drain_fire ? sb_if.store_request_address : sc_addr_q;
        end
    end
endmodule
